// File: rtl/upg_pkg.sv
// Shared types and default constants for the UART program-load mode controller.
package upg_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ENTER = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DRAIN = 2'd3
  } upg_state_e;

  localparam int UPG_ADDR_W   = 14;
  // Loader address bit that selects DMem (1) over IMem (0): the bit just above the word address.
  localparam int UPG_SEL_BIT  = UPG_ADDR_W;
  localparam int UPG_HOLD_CYC = 16;
  localparam int UPG_EXIT_CYC = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/upg_req_filter.sv
// start_pg conditioning: 2-flop synchronizer, hold counter and single-shot request pulse.
module upg_req_filter
  import upg_pkg::*;
#(
  parameter int HOLD_CYC = UPG_HOLD_CYC
) (
  input  logic clk,
  input  logic rstn,
  input  logic start_pg,
  output logic req
);

  localparam int CW = $clog2(HOLD_CYC + 1);

  logic [1:0]    sync_r;
  logic [CW-1:0] hold_r;
  logic          req_r;

  // Synchronize the button and fire once when the hold count reaches HOLD_CYC.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_r <= 2'b00;
      hold_r <= '0;
      req_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], start_pg};
      if (!sync_r[1]) begin
        hold_r <= '0;
        req_r  <= 1'b0;
      end else if (hold_r < CW'(HOLD_CYC)) begin
        hold_r <= hold_r + CW'(1);
        req_r  <= (hold_r == CW'(HOLD_CYC - 1));
      end else begin
        // Counter parks at HOLD_CYC until release, so no re-fire while held.
        req_r <= 1'b0;
      end
    end
  end

  assign req = req_r;

endmodule

// File: rtl/upg_mode_ctrl.sv
// CPU-run / UART program-load mode sequencer with loader write forwarding.
// Optional load-idle timeout is compiled in with `define UPG_TIMEOUT_EN.
module upg_mode_ctrl
  import upg_pkg::*;
#(
  parameter int ADDR_W      = UPG_ADDR_W,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYC    = UPG_HOLD_CYC,
  parameter int EXIT_CYC    = UPG_EXIT_CYC,
  parameter int TIMEOUT_CYC = 2**24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_pg,
  input  logic              upg_wen_i,
  input  logic [ADDR_W:0]   upg_adr_i,
  input  logic [DATA_W-1:0] upg_dat_i,
  input  logic              upg_done_i,
  output logic              upg_rst_o,
  output logic              cpu_rstn_o,
  output logic              imem_we_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic [15:0]       word_cnt_o,
  output logic              load_err_o
);

  localparam int XW = (EXIT_CYC > 1) ? $clog2(EXIT_CYC) : 1;

  upg_state_e        state_r;
  logic              req_s;
  logic              timeout_s;
  logic              upg_rst_r;
  logic              cpu_rstn_r;
  logic              imem_we_r;
  logic              dmem_we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              busy_r;
  logic [15:0]       word_cnt_r;
  logic              load_err_r;
  logic [XW-1:0]     exit_cnt_r;

  upg_req_filter #(
    .HOLD_CYC (HOLD_CYC)
  ) u_req_filter (
    .clk      (clk),
    .rstn     (rstn),
    .start_pg (start_pg),
    .req      (req_s)
  );

`ifdef UPG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_r;

  // Idle-write counter; held at zero outside LOAD so every LOAD entry starts fresh.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_r <= '0;
    end else if ((state_r != ST_LOAD) || upg_wen_i) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TW'(1);
    end
  end

  assign timeout_s = (state_r == ST_LOAD) && !upg_wen_i && (to_cnt_r == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Mode FSM with registered resets, busy flag and loader write forwarding.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_RUN;
      upg_rst_r  <= 1'b1;
      cpu_rstn_r <= 1'b1;
      imem_we_r  <= 1'b0;
      dmem_we_r  <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      busy_r     <= 1'b0;
      word_cnt_r <= 16'h0000;
      load_err_r <= 1'b0;
      exit_cnt_r <= '0;
    end else begin
      imem_we_r <= 1'b0;
      dmem_we_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (req_s) begin
            state_r    <= ST_ENTER;
            busy_r     <= 1'b1;
            cpu_rstn_r <= 1'b0;
            upg_rst_r  <= 1'b1;
            word_cnt_r <= 16'h0000;
            load_err_r <= 1'b0;
          end
        end
        ST_ENTER: begin
          state_r   <= ST_LOAD;
          upg_rst_r <= 1'b0;
        end
        ST_LOAD: begin
          // A strobe alongside done (or timeout) is still forwarded.
          if (upg_wen_i) begin
            addr_r     <= upg_adr_i[ADDR_W-1:0];
            wdata_r    <= upg_dat_i;
            imem_we_r  <= ~upg_adr_i[ADDR_W];
            dmem_we_r  <= upg_adr_i[ADDR_W];
            word_cnt_r <= sat_inc16(word_cnt_r);
          end
          if (upg_done_i) begin
            state_r    <= ST_DRAIN;
            upg_rst_r  <= 1'b1;
            exit_cnt_r <= '0;
          end else if (timeout_s) begin
            state_r    <= ST_DRAIN;
            upg_rst_r  <= 1'b1;
            exit_cnt_r <= '0;
            load_err_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (exit_cnt_r == XW'(EXIT_CYC - 1)) begin
            state_r    <= ST_RUN;
            cpu_rstn_r <= 1'b1;
            busy_r     <= 1'b0;
          end else begin
            exit_cnt_r <= exit_cnt_r + XW'(1);
          end
        end
        default: begin
          state_r    <= ST_RUN;
          upg_rst_r  <= 1'b1;
          cpu_rstn_r <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign upg_rst_o   = upg_rst_r;
  assign cpu_rstn_o  = cpu_rstn_r;
  assign imem_we_o   = imem_we_r;
  assign dmem_we_o   = dmem_we_r;
  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;
  assign busy_o      = busy_r;
  assign word_cnt_o  = word_cnt_r;
  assign load_err_o  = load_err_r;

endmodule

// File: tb/tb_upg_mode_ctrl.sv
// Self-checking bench for upg_mode_ctrl: write vector table, scoreboard of forwarded writes, mode sequences.
module tb_upg_mode_ctrl;

  localparam int ADDR_W      = 14;
  localparam int DATA_W      = 32;
  localparam int HOLD_CYC    = 16;
  localparam int EXIT_CYC    = 4;
  localparam int TIMEOUT_CYC = 100;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start_pg;
  logic              upg_wen_i;
  logic [ADDR_W:0]   upg_adr_i;
  logic [DATA_W-1:0] upg_dat_i;
  logic              upg_done_i;
  logic              upg_rst_o;
  logic              cpu_rstn_o;
  logic              imem_we_o;
  logic              dmem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              busy_o;
  logic [15:0]       word_cnt_o;
  logic              load_err_o;

  typedef struct {
    logic              imem;
    logic              dmem;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_exp_t;

  typedef struct {
    logic [ADDR_W:0]   adr;
    logic [DATA_W-1:0] dat;
    logic              exp_imem;
    logic              exp_dmem;
    logic [ADDR_W-1:0] exp_addr;
  } wr_vec_t;

  wr_vec_t vecs [5];
  wr_exp_t exp_q [$];
  int checks   = 0;
  int failures = 0;

  upg_mode_ctrl #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .HOLD_CYC    (HOLD_CYC),
    .EXIT_CYC    (EXIT_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start_pg    (start_pg),
    .upg_wen_i   (upg_wen_i),
    .upg_adr_i   (upg_adr_i),
    .upg_dat_i   (upg_dat_i),
    .upg_done_i  (upg_done_i),
    .upg_rst_o   (upg_rst_o),
    .cpu_rstn_o  (cpu_rstn_o),
    .imem_we_o   (imem_we_o),
    .dmem_we_o   (dmem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .busy_o      (busy_o),
    .word_cnt_o  (word_cnt_o),
    .load_err_o  (load_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [ADDR_W:0] adr, input logic [DATA_W-1:0] dat,
                             input logic im, input logic dm, input logic [ADDR_W-1:0] ea);
    wr_exp_t e;
    upg_wen_i = 1'b1;
    upg_adr_i = adr;
    upg_dat_i = dat;
    e.imem = im;
    e.dmem = dm;
    e.addr = ea;
    e.data = dat;
    exp_q.push_back(e);
  endtask

  // Press start_pg for 20 cycles and follow the RUN -> ENTER -> LOAD walk.
  task automatic enter_load();
    int n;
    n = 0;
    start_pg = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 20) start_pg = 1'b0;
      if (n == 0 && busy_o === 1'b1) begin
        n = i;
        check("enter_cpu_rstn", {31'd0, cpu_rstn_o}, 32'd0);
        check("enter_upg_rst", {31'd0, upg_rst_o}, 32'd1);
      end
      if (i >= 20 && n != 0) break;
    end
    start_pg = 1'b0;
    check("enter_latency", n, 32'd19);
    check("load_upg_rst", {31'd0, upg_rst_o}, 32'd0);
    check("load_cpu_rstn", {31'd0, cpu_rstn_o}, 32'd0);
    check("load_word_cnt", {16'd0, word_cnt_o}, 32'd0);
  endtask

  // Scoreboard: every enable pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we_o || dmem_we_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_we: imem=%0b dmem=%0b addr=0x%0h, none required", imem_we_o, dmem_we_o, mem_addr_o);
      end else begin
        wr_exp_t e;
        e = exp_q.pop_front();
        check("wr_imem", {31'd0, imem_we_o}, {31'd0, e.imem});
        check("wr_dmem", {31'd0, dmem_we_o}, {31'd0, e.dmem});
        check("wr_addr", {18'd0, mem_addr_o}, {18'd0, e.addr});
        check("wr_data", mem_wdata_o, e.data);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{adr: 15'h0005, dat: 32'hDEADBEEF, exp_imem: 1'b1, exp_dmem: 1'b0, exp_addr: 14'h0005};
    vecs[1] = '{adr: 15'h4010, dat: 32'h12345678, exp_imem: 1'b0, exp_dmem: 1'b1, exp_addr: 14'h0010};
    vecs[2] = '{adr: 15'h3FFF, dat: 32'hA5A5A5A5, exp_imem: 1'b1, exp_dmem: 1'b0, exp_addr: 14'h3FFF};
    vecs[3] = '{adr: 15'h4000, dat: 32'hFFFFFFFF, exp_imem: 1'b0, exp_dmem: 1'b1, exp_addr: 14'h0000};
    vecs[4] = '{adr: 15'h7FFF, dat: 32'h0BADF00D, exp_imem: 1'b0, exp_dmem: 1'b1, exp_addr: 14'h3FFF};

    rstn       = 1'b0;
    start_pg   = 1'b0;
    upg_wen_i  = 1'b0;
    upg_adr_i  = 15'h0000;
    upg_dat_i  = 32'h0;
    upg_done_i = 1'b0;
    tick(); tick(); tick();
    check("rst_upg_rst", {31'd0, upg_rst_o}, 32'd1);
    check("rst_cpu_rstn", {31'd0, cpu_rstn_o}, 32'd1);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_word_cnt", {16'd0, word_cnt_o}, 32'd0);
    check("rst_load_err", {31'd0, load_err_o}, 32'd0);
    check("rst_addr", {18'd0, mem_addr_o}, 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    rstn = 1'b1;
    tick();

    // Short press (10 cycles) must not leave RUN.
    start_pg = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) start_pg = 1'b0;
      tick();
      if (busy_o !== 1'b0) n++;
    end
    check("short_press_busy_cycles", n, 32'd0);

    // Full press, then the write vector table.
    enter_load();
    for (int i = 0; i < 5; i++) begin
      drive_write(vecs[i].adr, vecs[i].dat, vecs[i].exp_imem, vecs[i].exp_dmem, vecs[i].exp_addr);
      tick();
      check("table_word_cnt", {16'd0, word_cnt_o}, i + 1);
    end
    upg_wen_i = 1'b0;
    tick(); tick();
    check("hold_addr", {18'd0, mem_addr_o}, 32'h3FFF);
    check("hold_wdata", mem_wdata_o, 32'h0BADF00D);

    // Button re-pressed during LOAD is ignored.
    start_pg = 1'b1;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (upg_rst_o !== 1'b0 || busy_o !== 1'b1) n++;
    end
    start_pg = 1'b0;
    tick(); tick(); tick();
    check("load_repress_cycles", n, 32'd0);

    // Final write together with done, then the DRAIN window.
    drive_write(15'h0001, 32'hCAFEF00D, 1'b1, 1'b0, 14'h0001);
    upg_done_i = 1'b1;
    tick();
    upg_wen_i  = 1'b0;
    upg_done_i = 1'b0;
    check("drain_upg_rst", {31'd0, upg_rst_o}, 32'd1);
    check("drain_busy", {31'd0, busy_o}, 32'd1);
    n = 0;
    while (cpu_rstn_o === 1'b0 && n < 20) begin
      n++;
      tick();
    end
    check("drain_cycles", n, EXIT_CYC);
    check("run_busy", {31'd0, busy_o}, 32'd0);
    check("run_upg_rst", {31'd0, upg_rst_o}, 32'd1);
    check("run_word_cnt", {16'd0, word_cnt_o}, 32'd6);
    check("run_load_err", {31'd0, load_err_o}, 32'd0);

    // Strobes in RUN are dropped and the write registers hold.
    upg_wen_i = 1'b1;
    upg_adr_i = 15'h4002;
    upg_dat_i = 32'h11112222;
    tick(); tick(); tick();
    upg_wen_i = 1'b0;
    tick();
    check("run_strobe_busy", {31'd0, busy_o}, 32'd0);
    check("run_strobe_addr", {18'd0, mem_addr_o}, 32'h0001);
    check("run_strobe_wdata", mem_wdata_o, 32'hCAFEF00D);
    check("run_strobe_cnt", {16'd0, word_cnt_o}, 32'd6);

    // Async reset mid-load after three writes.
    enter_load();
    for (int i = 0; i < 3; i++) begin
      drive_write(vecs[i].adr, vecs[i].dat, vecs[i].exp_imem, vecs[i].exp_dmem, vecs[i].exp_addr);
      tick();
    end
    upg_wen_i = 1'b0;
    tick();
    check("pre_reset_cnt", {16'd0, word_cnt_o}, 32'd3);
    upg_wen_i = 1'b1;
    upg_adr_i = 15'h0123;
    upg_dat_i = 32'h55AA55AA;
    #2;
    rstn = 1'b0;
    #1;
    check("arst_cpu_rstn", {31'd0, cpu_rstn_o}, 32'd1);
    check("arst_upg_rst", {31'd0, upg_rst_o}, 32'd1);
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_word_cnt", {16'd0, word_cnt_o}, 32'd0);
    check("arst_addr", {18'd0, mem_addr_o}, 32'd0);
    check("arst_wdata", mem_wdata_o, 32'd0);
    check("arst_we", {30'd0, imem_we_o, dmem_we_o}, 32'd0);
    tick();
    upg_wen_i = 1'b0;
    rstn = 1'b1;
    tick(); tick(); tick();
    check("post_arst_busy", {31'd0, busy_o}, 32'd0);

    // One write then an idle loader.
    enter_load();
    drive_write(15'h0042, 32'h00C0FFEE, 1'b1, 1'b0, 14'h0042);
    tick();
    upg_wen_i = 1'b0;
    n = 0;
    while (load_err_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
`ifdef UPG_TIMEOUT_EN
    check("timeout_cycles", n, TIMEOUT_CYC);
    check("timeout_upg_rst", {31'd0, upg_rst_o}, 32'd1);
    check("timeout_busy", {31'd0, busy_o}, 32'd1);
`else
    check("no_timeout_err", {31'd0, load_err_o}, 32'd0);
    check("no_timeout_load", {30'd0, busy_o, upg_rst_o}, 32'd2);
    upg_done_i = 1'b1;
    tick();
    upg_done_i = 1'b0;
`endif
    n = 0;
    while (cpu_rstn_o === 1'b0 && n < 20) begin
      n++;
      tick();
    end
    check("idle_exit_cycles", n, EXIT_CYC);
    check("idle_busy", {31'd0, busy_o}, 32'd0);
    check("idle_word_cnt", {16'd0, word_cnt_o}, 32'd1);
`ifdef UPG_TIMEOUT_EN
    check("idle_load_err", {31'd0, load_err_o}, 32'd1);
`else
    check("idle_load_err", {31'd0, load_err_o}, 32'd0);
`endif

    tick(); tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
